// File: rtl/mult_seq_pkg.sv
// Shared types for the multiplier request sequencer: FSM state encoding and
// the operand FIFO entry width (one multiplier/multiplicand pair).
package mult_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // A FIFO entry packs {multiplier, multiplicand}, so it is twice the operand width.
  function automatic int entry_width(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/mult_operand_fifo.sv
// Synchronous operand FIFO: registered storage, combinational head read,
// occupancy count of width clog2(DEPTH)+1 driving full/empty.
module mult_operand_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/multiplier_request_sequencer.sv
// Streaming front end for the sequential multiplier: one operation in flight,
// results delivered in push order. Define MULT_SEQ_TIMEOUT_EN for the WAIT watchdog.
module multiplier_request_sequencer
  import mult_seq_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 4*WIDTH+8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_multiplier,
  input  logic [WIDTH-1:0]   in_multiplicand,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_multiplier,
  output logic [WIDTH-1:0]   mul_multiplicand,
  input  logic [2*WIDTH-1:0] mul_product,
  input  logic               mul_done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic               busy,
  output logic               error,
  output logic [1:0]         dbg_state
);

  localparam int EW = entry_width(WIDTH);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready;
  // valid never depends combinationally on ready on the same side.
  state_t             state_q;
  logic               start_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               done_q;
  logic               out_valid_q;
  logic [2*WIDTH-1:0] product_q;

  logic               fifo_full;
  logic               fifo_empty;
  logic [EW-1:0]      fifo_head;
  logic               push;
  logic               pop;
  logic               done_edge;

  assign in_ready  = !fifo_full;
  assign push      = in_valid && !fifo_full;
  // Issue only into a free or draining result slot so capture never overwrites.
  assign pop       = (state_q == ST_IDLE) && !fifo_empty && (!out_valid_q || out_ready);
  assign done_edge = mul_done && !done_q;

  mult_operand_fifo #(.DW(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({in_multiplier, in_multiplicand}),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef MULT_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES+1);
  logic [CW-1:0] wait_cnt_q;
  logic          error_q;
  logic          timeout;
  assign timeout = (wait_cnt_q == CW'(TIMEOUT_CYCLES-1));
  assign error   = error_q;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      product_q   <= '0;
`ifdef MULT_SEQ_TIMEOUT_EN
      wait_cnt_q  <= '0;
      error_q     <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
      done_q  <= mul_done;
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            {a_q, b_q} <= fifo_head;
            start_q    <= 1'b1;
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
`ifdef MULT_SEQ_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end
        ST_WAIT: begin
          if (done_edge) begin
            product_q   <= mul_product;
            out_valid_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
`ifdef MULT_SEQ_TIMEOUT_EN
          else if (timeout) begin
            error_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
          end
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mul_start        = start_q;
  assign mul_multiplier   = a_q;
  assign mul_multiplicand = b_q;
  assign out_valid        = out_valid_q;
  assign out_product      = product_q;
  assign busy             = (state_q != ST_IDLE) || !fifo_empty;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_multiplier_request_sequencer.sv
// Self-checking bench for multiplier_request_sequencer with a behavioural
// multiplier model; covers MULT_SEQ_TIMEOUT_EN both defined and undefined.
module tb_multiplier_request_sequencer;
  import mult_seq_pkg::*;

  localparam int WIDTH          = 8;
  localparam int DEPTH          = 4;
  localparam int TIMEOUT_CYCLES = 4*WIDTH+8;
  localparam int PW             = 2*WIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_multiplier = '0;
  logic [WIDTH-1:0] in_multiplicand = '0;
  logic             mul_start;
  logic [WIDTH-1:0] mul_multiplier;
  logic [WIDTH-1:0] mul_multiplicand;
  logic [PW-1:0]    mul_product;
  logic             mul_done;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [PW-1:0]    out_product;
  logic             busy;
  logic             error;
  logic [1:0]       dbg_state;

  multiplier_request_sequencer #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_multiplier    (in_multiplier),
    .in_multiplicand  (in_multiplicand),
    .mul_start        (mul_start),
    .mul_multiplier   (mul_multiplier),
    .mul_multiplicand (mul_multiplicand),
    .mul_product      (mul_product),
    .mul_done         (mul_done),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_product      (out_product),
    .busy             (busy),
    .error            (error),
    .dbg_state        (dbg_state)
  );

  // ---------------- multiplier model ----------------
  int            lat = 20;
  bit            level_done = 0;
  bit            never_done = 0;
  int            m_cnt;
  bit            m_busy;
  logic [PW-1:0] m_prod;

  always @(posedge clk) begin
    if (rst) begin
      m_busy      <= 0;
      m_cnt       <= 0;
      m_prod      <= '0;
      mul_done    <= 1'b0;
      mul_product <= '0;
    end else begin
      if (!level_done) mul_done <= 1'b0;
      if (mul_start) begin
        m_busy   <= 1;
        m_cnt    <= lat - 1;
        mul_done <= 1'b0;
        m_prod   <= PW'(mul_multiplier) * PW'(mul_multiplicand);
      end else if (m_busy && never_done) begin
        m_busy <= 0;
      end else if (m_busy) begin
        if (m_cnt == 0) begin
          m_busy      <= 0;
          mul_done    <= 1'b1;
          mul_product <= m_prod;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] opnd_q[$];
  bit            inflight  = 0;
  logic          prev_ov   = 1'b0;
  logic          prev_err  = 1'b0;
  int            start_cyc = 0;
  int            n_results = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      opnd_q.delete();
      inflight = 0;
      prev_ov  = 1'b0;
      prev_err = 1'b0;
    end else begin
      if ((out_valid && !prev_ov) || (error && !prev_err)) inflight = 0;
      prev_ov  = out_valid;
      prev_err = error;
      if (mul_start) begin
        check_eq("start_while_in_flight", 32'(inflight), 32'd0);
        inflight  = 1;
        start_cyc = cyc;
        if (opnd_q.size() == 0) begin
          check_eq("start_without_op", 32'(opnd_q.size()), 32'd1);
        end else begin
          logic [PW-1:0] op;
          op = opnd_q.pop_front();
          check_eq("start_multiplier", 32'(mul_multiplier), 32'(op[PW-1:WIDTH]));
          check_eq("start_multiplicand", 32'(mul_multiplicand), 32'(op[WIDTH-1:0]));
        end
      end
      if (out_valid && out_ready) begin
        n_results++;
        if (exp_q.size() == 0) begin
          check_eq("result_without_exp", 32'(exp_q.size()), 32'd1);
        end else begin
          check_eq("product_order", 32'(out_product), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; the push lands on the following rising edge.
  task automatic push_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, output bit acc);
    in_valid        = 1'b1;
    in_multiplier   = a;
    in_multiplicand = b;
    acc             = in_ready;
    if (acc) begin
      exp_q.push_back(PW'(a) * PW'(b));
      opnd_q.push_back({a, b});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (!(exp_q.size() == 0 && !busy && !out_valid) && k < budget) begin
      step(1);
      k++;
    end
    if (k >= budget)
      check_eq("drain_timeout", 32'({busy, out_valid, exp_q.size() != 0}), 32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- test sequence ----------------
  initial begin
    bit acc;
    int k;
    int acc_cnt;
    int res0;
    logic [PW-1:0] held;

    // Reset values
    step(2);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_mul_start", 32'(mul_start), 32'd0);
    check_eq("rst_operands", 32'({mul_multiplier, mul_multiplicand}), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_product", 32'(out_product), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_error", 32'(error), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    step(1);

    // Single op 13x11: start at t+2, result one cycle after done, held
    lat = 20;
    out_ready = 1'b0;
    push_op(8'd13, 8'd11, acc);
    check_eq("t1_accept", 32'(acc), 32'd1);
    check_eq("t1_no_start_t1", 32'(mul_start), 32'd0);
    step(1);
    check_eq("t1_start_t2", 32'(mul_start), 32'd1);
    check_eq("t1_op_a", 32'(mul_multiplier), 32'd13);
    check_eq("t1_op_b", 32'(mul_multiplicand), 32'd11);
    step(1);
    check_eq("t1_start_one_cycle", 32'(mul_start), 32'd0);
    k = 0;
    while (!mul_done && k < 100) begin step(1); k++; end
    check_eq("t1_done_seen", 32'(mul_done), 32'd1);
    check_eq("t1_ov_not_yet", 32'(out_valid), 32'd0);
    step(1);
    check_eq("t1_out_valid", 32'(out_valid), 32'd1);
    check_eq("t1_product", 32'(out_product), 32'd143);
    push_op(8'd2, 8'd3, acc);
    held = out_product;
    repeat (10) begin
      check_eq("hold_product", 32'(out_product), 32'(held));
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_no_start", 32'(mul_start), 32'd0);
      check_eq("hold_busy", 32'(busy), 32'd1);
      step(1);
    end
    out_ready = 1'b1;
    wait_drain(200);

    // Back-to-back edge cases with level-style done
    level_done = 1;
    lat = 5;
    res0 = n_results;
    push_op(8'd255, 8'd255, acc); check_eq("t2_acc0", 32'(acc), 32'd1);
    push_op(8'd0,   8'd7,   acc); check_eq("t2_acc1", 32'(acc), 32'd1);
    push_op(8'd1,   8'd200, acc); check_eq("t2_acc2", 32'(acc), 32'd1);
    push_op(8'd128, 8'd2,   acc); check_eq("t2_acc3", 32'(acc), 32'd1);
    wait_drain(300);
    check_eq("t2_results", 32'(n_results - res0), 32'd4);
    level_done = 0;
    step(2);

    // Backpressure: 7 attempts, exactly 5 accepted
    lat = 20;
    out_ready = 1'b0;
    acc_cnt = 0;
    res0 = n_results;
    for (int i = 0; i < 7; i++) begin
      push_op(WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)), acc);
      if (acc) acc_cnt++;
    end
    check_eq("t3_accepted", 32'(acc_cnt), 32'd5);
    check_eq("t3_in_ready_low", 32'(in_ready), 32'd0);
    step(40);
    check_eq("t3_result_held", 32'(out_valid), 32'd1);
    check_eq("t3_still_full", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    wait_drain(500);
    check_eq("t3_drained", 32'(n_results - res0), 32'd5);

    // Reset during WAIT with two ops queued
    push_op(8'd10, 8'd10, acc);
    push_op(8'd20, 8'd20, acc);
    push_op(8'd30, 8'd30, acc);
    k = 0;
    while (dbg_state != 2'(ST_WAIT) && k < 20) begin step(1); k++; end
    check_eq("t4_in_wait", 32'(dbg_state), 32'(ST_WAIT));
    pulse_reset();
    check_eq("t4_out_valid", 32'(out_valid), 32'd0);
    check_eq("t4_in_ready", 32'(in_ready), 32'd1);
    check_eq("t4_busy", 32'(busy), 32'd0);
    res0 = n_results;
    push_op(8'd3, 8'd5, acc);
    wait_drain(200);
    check_eq("t4_fresh_result", 32'(n_results - res0), 32'd1);

    // Watchdog / unbounded WAIT
    never_done = 1;
    push_op(8'd9, 8'd9, acc);
    void'(exp_q.pop_front());
`ifdef MULT_SEQ_TIMEOUT_EN
    k = 0;
    while (!error && k < TIMEOUT_CYCLES + 60) begin step(1); k++; end
    check_eq("to_error_set", 32'(error), 32'd1);
    check_eq("to_latency", 32'(cyc - start_cyc), 32'(TIMEOUT_CYCLES + 1));
    check_eq("to_no_result", 32'(out_valid), 32'd0);
    check_eq("to_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    never_done = 0;
    res0 = n_results;
    push_op(8'd6, 8'd7, acc);
    wait_drain(200);
    check_eq("to_next_op", 32'(n_results - res0), 32'd1);
    check_eq("to_error_sticky", 32'(error), 32'd1);
`else
    step(TIMEOUT_CYCLES + 20);
    check_eq("hang_error_zero", 32'(error), 32'd0);
    check_eq("hang_state_wait", 32'(dbg_state), 32'(ST_WAIT));
    check_eq("hang_no_result", 32'(out_valid), 32'd0);
    pulse_reset();
    never_done = 0;
    res0 = n_results;
    push_op(8'd6, 8'd7, acc);
    wait_drain(200);
    check_eq("hang_next_op", 32'(n_results - res0), 32'd1);
`endif

    check_eq("final_exp_empty", 32'(exp_q.size()), 32'd0);
    check_eq("final_opnd_empty", 32'(opnd_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
